stream_arbiter: RTL and testbench

- Shares the single 256-bit stream write port of the FX3 output path between N_REQ independent data producers, e.g. TDC channel packers and a status/telemetry source.
- Grants round-robin bursts of at most BURST_MAX words and prefixes each burst with a header word identifying the source.
- Honours FIFO backpressure (full / prog_full).
- When all sources stay idle for IDLE_TIMEOUT cycles, emits a heartbeat header so the host-side stream never stalls waiting for a packet end.
- Sits in the stream clock domain, directly upstream of the FX3 writer's stream_* inputs.

---
 rtl/stream_arb_pkg.sv | 32 +++
 rtl/stream_arbiter_rr_pick.sv | 30 +++
 rtl/stream_arbiter.sv | 164 ++++++++++++++++
 tb/tb_stream_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and header-word construction for the stream arbiter and its helpers.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HEADER    = 2'd1,
    ST_BURST     = 2'd2,
    ST_HEARTBEAT = 2'd3
  } state_e;

  localparam int unsigned HDR_W        = 256;
  localparam logic [7:0]  HDR_MARKER   = 8'hA5;
  localparam logic [7:0]  HB_ID        = 8'hFF;
  localparam int unsigned HDR_MARK_LSB = 248;
  localparam int unsigned HDR_ID_LSB   = 240;
  localparam int unsigned HDR_TS_LSB   = 208;
  localparam int unsigned HDR_SEQ_LSB  = 192;

  // Marker, source id, timestamp and sequence; all lower bits stay zero.
  function automatic logic [HDR_W-1:0] build_header(input logic [7:0]  id,
                                                    input logic [31:0] ts,
                                                    input logic [15:0] seq);
    logic [HDR_W-1:0] h;
    h                       = '0;
    h[HDR_MARK_LSB +: 8]    = HDR_MARKER;
    h[HDR_ID_LSB   +: 8]    = id;
    h[HDR_TS_LSB   +: 32]   = ts;
    h[HDR_SEQ_LSB  +: 16]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of valid_i at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found_c = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % N);
      if (!found_c && valid_i[cand]) begin
        found_c       = 1'b1;
        idx_c         = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin burst arbiter feeding the FX3 stream FIFO: header-prefixed bursts,
// FIFO backpressure, and idle heartbeats so the host stream never stalls.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned BURST_MAX    = 16,
  parameter int unsigned IDLE_TIMEOUT = 65536,
  parameter bit          HB_EN        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       stream_data_o,
  output logic                    stream_write_o,
  input  logic                    stream_full_i,
  input  logic                    stream_prog_full_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o,
  output logic [31:0]             burst_count_o
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [15:0]         seq_q, seq_d;
  logic [31:0]         ts_q, ts_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                write_q, write_d;

  logic                space_c;
  logic                burst_open_c;
  logic                xfer_c;
  logic [DATA_W-1:0]   gword_c;
  logic [N_REQ-1:0]    pick_grant_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic                pick_found_c;

  rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .found_c (pick_found_c)
  );

  // Ready is combinational so a full FIFO stops transfers in the same cycle.
  assign space_c      = !stream_full_i && !stream_prog_full_i;
  assign burst_open_c = (state_q == ST_BURST) && space_c && (beat_q < BEAT_LAST);
  assign xfer_c       = burst_open_c && req_valid_i[gidx_q];
  assign gword_c      = req_data_i[32'(gidx_q)*DATA_W +: DATA_W];
  assign req_ready_o  = burst_open_c ? grant_q : '0;

  assign stream_data_o  = data_q;
  assign stream_write_o = write_q;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign burst_count_o  = cnt_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    write_d  = 1'b0;
    ts_d     = ts_q + 32'd1;
    idle_d   = idle_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i && space_c && pick_found_c) begin
          gidx_d  = pick_idx_c;
          grant_d = pick_grant_c;
          state_d = ST_HEADER;
        end else if (HB_EN && space_c && (idle_q == IDLE_LAST)) begin
          state_d = ST_HEARTBEAT;
        end
      end
      ST_HEADER: begin
        data_d  = build_header(8'(gidx_q), ts_q, seq_q);
        write_d = 1'b1;
        seq_d   = seq_q + 16'd1;
        cnt_d   = cnt_q + 32'd1;
        beat_d  = '0;
        state_d = ST_BURST;
      end
      ST_BURST: begin
        if (xfer_c) begin
          data_d  = gword_c;
          write_d = 1'b1;
          beat_d  = beat_q + BEAT_W'(1);
        end
        // An acknowledged word is always forwarded, even on the exit cycle.
        if (!xfer_c || !enable_i || (beat_q + BEAT_W'(1) == BEAT_LAST)) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + IDX_W'(1);
        end
      end
      ST_HEARTBEAT: begin
        data_d  = build_header(HB_ID, ts_q, seq_q);
        write_d = 1'b1;
        seq_d   = seq_q + 16'd1;
        cnt_d   = cnt_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle timer runs only while truly idle; any activity restarts it.
    if ((state_q != ST_IDLE) || write_q || (|req_valid_i)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
      seq_q    <= '0;
      ts_q     <= '0;
      idle_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      seq_q    <= seq_d;
      ts_q     <= ts_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      write_q  <= write_d;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference of the arbitration rules.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int BM = 16;
  localparam int T  = 100;
  localparam int P_IDLE = 0, P_HDR = 1, P_BURST = 2, P_HB = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_valid_i, req_ready_o, grant_o;
  logic [W-1:0]   stream_data_o;
  logic           stream_write_o, stream_full_i, stream_prog_full_i, busy_o;
  logic [31:0]    burst_count_o;

  stream_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_MAX(BM), .IDLE_TIMEOUT(T), .HB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .req_data_i(req_data_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .stream_data_o(stream_data_o),
    .stream_write_o(stream_write_o), .stream_full_i(stream_full_i),
    .stream_prog_full_i(stream_prog_full_i), .grant_o(grant_o), .busy_o(busy_o),
    .burst_count_o(burst_count_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [W-1:0] data; } wr_t;
  wr_t dut_log[$];
  wr_t exp_log[$];

  int errors = 0, checks = 0;
  int cyc, ctl_diff;
  bit en_k, pf_k;
  bit gate[N];
  int src_next[N], src_end[N];

  int m_phase, m_owner, m_ptr, m_beats, m_idle, m_count;
  logic [31:0] m_ts;
  logic [15:0] m_seq;
  bit m_wr;

  function automatic logic [W-1:0] mkword(int k, int i);
    return {8'(8'h10 + k), 216'h0, 32'(i)};
  endfunction

  function automatic logic [W-1:0] hdr(logic [7:0] id, logic [31:0] ts, logic [15:0] seq);
    return {8'hA5, id, ts, seq, 192'h0};
  endfunction

  function automatic int log_diff();
    int n;
    n = (dut_log.size() < exp_log.size()) ? dut_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      if (dut_log[i].cyc != exp_log[i].cyc || dut_log[i].data !== exp_log[i].data) return i;
    if (dut_log.size() != exp_log.size()) return n;
    return -1;
  endfunction

  function automatic string diff_str(int d);
    string s;
    s = $sformatf("entry %0d (dut %0d writes, model %0d writes):", d, dut_log.size(), exp_log.size());
    if (d < dut_log.size()) s = {s, $sformatf(" actual cyc %0d %h", dut_log[d].cyc, dut_log[d].data)};
    if (d < exp_log.size()) s = {s, $sformatf(" required cyc %0d %h", exp_log[d].cyc, exp_log[d].data)};
    return s;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]        = gate[k] && (src_next[k] < src_end[k]);
      req_data_i[k*W +: W]  = mkword(k, src_next[k]);
    end
    enable_i           = en_k;
    stream_prog_full_i = pf_k;
    stream_full_i      = 1'b0;
  endtask

  // One clock: drive, predict with the reference, then record what the DUT wrote.
  task automatic step();
    logic [N-1:0] er, eg;
    logic [W-1:0] nd;
    bit sp, nw, clr, x;
    int k;
    drive();
    #1;
    sp = !stream_full_i && !stream_prog_full_i;
    er = '0;
    if (m_phase == P_BURST && sp && m_beats < BM) er[m_owner] = 1'b1;
    if (req_ready_o !== er) ctl_diff++;
    nw  = 0;
    nd  = '0;
    clr = (m_phase != P_IDLE) || m_wr || (req_valid_i != '0);
    case (m_phase)
      P_IDLE: begin
        if (en_k && sp && req_valid_i != '0) begin
          for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (m_owner < 0 && req_valid_i[k]) m_owner = k;
          end
          m_phase = P_HDR;
        end else if (sp && m_idle == T - 1) begin
          m_phase = P_HB;
        end
      end
      P_HDR: begin
        nw = 1; nd = hdr(8'(m_owner), m_ts, m_seq);
        m_seq++; m_count++; m_beats = 0; m_phase = P_BURST;
      end
      P_BURST: begin
        x = req_valid_i[m_owner] && er[m_owner];
        if (x) begin
          nw = 1; nd = mkword(m_owner, src_next[m_owner]);
          m_beats++; src_next[m_owner]++;
        end
        if (!x || !en_k || m_beats == BM) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_phase = P_IDLE;
        end
      end
      default: begin
        nw = 1; nd = hdr(8'hFF, m_ts, m_seq);
        m_seq++; m_count++; m_phase = P_IDLE;
      end
    endcase
    m_idle = clr ? 0 : ((m_idle < T - 1) ? m_idle + 1 : m_idle);
    m_ts++;
    m_wr = nw;
    if (nw) exp_log.push_back('{cyc + 1, nd});
    @(posedge clk); #1;
    cyc++;
    if (stream_write_o) dut_log.push_back('{cyc, stream_data_o});
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (grant_o !== eg || busy_o !== (m_phase != P_IDLE) || burst_count_o !== 32'(m_count)) ctl_diff++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en_k = 1; pf_k = 0;
    for (int k = 0; k < N; k++) begin gate[k] = 0; src_next[k] = 0; src_end[k] = 0; end
    drive();
    @(negedge clk); @(negedge clk);
    m_phase = P_IDLE; m_owner = -1; m_ptr = 0; m_beats = 0; m_idle = 0; m_count = 0;
    m_ts = '0; m_seq = '0; m_wr = 0;
    dut_log.delete(); exp_log.delete();
    cyc = 0; ctl_diff = 0;
    rst = 1'b0;
  endtask

  task automatic check_logs(string name);
    int d;
    d = log_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL %s stream: %s", name, diff_str(d)); end
    checks++;
    if (ctl_diff != 0) begin
      errors++; $display("FAIL %s control: %0d cycles with ready/grant/busy/count off, required 0", name, ctl_diff);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (stream_write_o !== 1'b0) begin errors++; $display("FAIL reset write: actual %b required 0", stream_write_o); end
    if (stream_data_o !== '0) begin errors++; $display("FAIL reset data: actual %h required 0", stream_data_o); end
    if (req_ready_o !== '0) begin errors++; $display("FAIL reset ready: actual %b required 0", req_ready_o); end
    if (grant_o !== '0) begin errors++; $display("FAIL reset grant: actual %b required 0", grant_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: actual %b required 0", busy_o); end
    if (burst_count_o !== 32'd0) begin errors++; $display("FAIL reset count: actual %0d required 0", burst_count_o); end
  endtask

  task automatic test_single_stream();
    logic [W-1:0] d, e;
    int bad;
    do_reset();
    gate[0] = 1; src_next[0] = 1; src_end[0] = 21;
    repeat (45) step();
    checks++;
    if (dut_log.size() != 22) begin
      errors++; $display("FAIL single_count: actual %0d writes required 22", dut_log.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 22; i++) begin
        d = dut_log[i].data;
        if (i == 0 || i == 17) e = {8'hA5, 8'h00, d[239:208], 16'(i == 17), 192'h0};
        else e = mkword(0, (i < 17) ? i : i - 1);
        if (d !== e && bad < 0) bad = i;
      end
      checks++;
      if (bad >= 0) begin
        errors++; $display("FAIL single_seq: entry %0d actual %h", bad, dut_log[bad].data);
      end
      checks++;
      if (dut_log[0].cyc != 2 || dut_log[16].cyc != 18 || dut_log[17].cyc != 20 || dut_log[21].cyc != 24) begin
        errors++;
        $display("FAIL single_timing: actual cycles %0d/%0d/%0d/%0d required 2/18/20/24",
                 dut_log[0].cyc, dut_log[16].cyc, dut_log[17].cyc, dut_log[21].cyc);
      end
      d = dut_log[0].data;
      checks++;
      if (d[239:208] !== 32'd1) begin errors++; $display("FAIL single_ts: actual %0d required 1", d[239:208]); end
    end
    check_logs("single");
  endtask

  task automatic test_all_four();
    int hidx[$];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] d;
    bit seen5;
    do_reset();
    for (int k = 0; k < N; k++) begin gate[k] = 1; src_end[k] = 40; end
    seen5 = 0;
    for (int i = 0; i < 200 && !seen5; i++) begin
      step();
      if (stream_write_o && stream_data_o[255:248] == 8'hA5) begin
        hidx.push_back(dut_log.size() - 1);
        if (hidx.size() == 5) begin
          seen5 = 1;
          checks++;
          if (burst_count_o !== 32'd5) begin
            errors++; $display("FAIL rr_count: actual %0d required 5", burst_count_o);
          end
        end
      end
    end
    checks++;
    if (!seen5) begin
      errors++; $display("FAIL rr_timeout: actual %0d headers required 5 within 200 cycles", hidx.size());
    end else begin
      for (int h = 0; h < 5; h++) begin
        d = dut_log[hidx[h]].data;
        checks++;
        if (d[247:240] !== 8'(exp_ids[h])) begin
          errors++; $display("FAIL rr_id%0d: actual %0d required %0d", h, d[247:240], exp_ids[h]);
        end
      end
      for (int h = 0; h < 4; h++) begin
        checks++;
        if (hidx[h+1] - hidx[h] - 1 != BM) begin
          errors++; $display("FAIL rr_len%0d: actual %0d required %0d", h, hidx[h+1] - hidx[h] - 1, BM);
        end
      end
    end
    check_logs("rr");
  endtask

  task automatic test_backpressure();
    int n0, i;
    logic [W-1:0] d;
    bit found;
    do_reset();
    gate[1] = 1; src_end[1] = 40;
    i = 0;
    while (i < 60 && !(m_phase == P_BURST && m_beats == 5)) begin step(); i++; end
    checks++;
    if (i == 60) begin errors++; $display("FAIL bp_reach: actual beat %0d required 5", m_beats); end
    pf_k = 1;
    n0 = dut_log.size();
    repeat (10) step();
    checks++;
    if (dut_log.size() - n0 > 1) begin
      errors++; $display("FAIL bp_stop: actual %0d writes after prog_full required <=1", dut_log.size() - n0);
    end
    gate[3] = 1; src_end[3] = 40; pf_k = 0;
    repeat (30) step();
    found = 0;
    for (int j = n0; j < dut_log.size() && !found; j++) begin
      d = dut_log[j].data;
      if (d[255:248] == 8'hA5) begin
        found = 1;
        checks++;
        if (d[247:240] !== 8'd3) begin errors++; $display("FAIL bp_next: actual id %0d required 3", d[247:240]); end
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_resume: actual no header required header after release"); end
    check_logs("bp");
  endtask

  task automatic test_heartbeat();
    logic [W-1:0] d;
    bit hb;
    do_reset();
    repeat (105) step();
    checks++;
    if (dut_log.size() < 1) begin
      errors++; $display("FAIL hb_none: actual 0 writes required heartbeat at cycle 101");
    end else begin
      d = dut_log[0].data;
      checks++;
      if (dut_log[0].cyc != 101 || d !== hdr(8'hFF, 32'd100, 16'd0)) begin
        errors++; $display("FAIL hb_word: actual cyc %0d %h required cyc 101 %h", dut_log[0].cyc, d, hdr(8'hFF, 32'd100, 16'd0));
      end
    end
    check_logs("hb");
    do_reset();
    repeat (99) step();
    gate[3] = 1; src_end[3] = 5;
    repeat (20) step();
    hb = 0;
    foreach (dut_log[j]) begin d = dut_log[j].data; if (d[255:240] == 16'hA5FF) hb = 1; end
    checks++;
    if (hb) begin errors++; $display("FAIL hb_race: actual heartbeat present required none"); end
    checks++;
    if (dut_log.size() < 1) begin
      errors++; $display("FAIL hb_race_hdr: actual 0 writes required header at 101");
    end else begin
      d = dut_log[0].data;
      if (dut_log[0].cyc != 101 || d[247:240] !== 8'd3) begin
        errors++; $display("FAIL hb_race_hdr: actual cyc %0d id %0d required cyc 101 id 3", dut_log[0].cyc, d[247:240]);
      end
    end
    check_logs("hb_race");
  endtask

  task automatic test_reset_mid_burst();
    logic [W-1:0] d;
    do_reset();
    gate[2] = 1; src_end[2] = 30;
    repeat (8) step();
    rst = 1'b1;
    #1;
    checks++;
    if (stream_write_o !== 1'b0 || req_ready_o !== '0 || grant_o !== '0) begin
      errors++; $display("FAIL rst_async: actual write %b ready %b grant %b required 0/0/0", stream_write_o, req_ready_o, grant_o);
    end
    do_reset();
    gate[1] = 1; gate[3] = 1; src_end[1] = 5; src_end[3] = 5;
    repeat (12) step();
    checks++;
    if (dut_log.size() < 1) begin
      errors++; $display("FAIL rst_first: actual 0 writes required header");
    end else begin
      d = dut_log[0].data;
      if (d[255:248] !== 8'hA5 || d[247:240] !== 8'd1 || d[207:192] !== 16'd0) begin
        errors++; $display("FAIL rst_first: actual %h required header id 1 seq 0", d);
      end
    end
    check_logs("rst_mid");
  endtask

  task automatic test_enable();
    int c0, n0;
    logic [W-1:0] d;
    bit hb;
    do_reset();
    en_k = 0; gate[0] = 1; gate[2] = 1; src_end[0] = 10; src_end[2] = 10;
    repeat (150) step();
    checks++;
    if (dut_log.size() != 0) begin errors++; $display("FAIL en_off: actual %0d writes required 0", dut_log.size()); end
    en_k = 1; c0 = cyc;
    repeat (5) step();
    checks++;
    if (dut_log.size() < 1 || dut_log[0].cyc > c0 + 2) begin
      errors++; $display("FAIL en_start: actual %0d writes, first at %0d, required first by cycle %0d", dut_log.size(),
                         (dut_log.size() > 0) ? dut_log[0].cyc : -1, c0 + 2);
    end
    en_k = 0; gate[0] = 0; gate[2] = 0;
    n0 = dut_log.size();
    repeat (120) step();
    hb = 0;
    for (int j = n0; j < dut_log.size(); j++) begin d = dut_log[j].data; if (d[255:240] == 16'hA5FF) hb = 1; end
    checks++;
    if (!hb) begin errors++; $display("FAIL en_hb: actual no heartbeat required heartbeat while disabled"); end
    check_logs("enable");
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    int hbs;
    do_reset();
    for (int k = 0; k < N; k++) begin gate[k] = ($urandom_range(0, 1) == 1); src_end[k] = 1000000; end
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 9) == 0) gate[k] = !gate[k];
      if (i % 600 >= 450) for (int k = 0; k < N; k++) gate[k] = 0;
      if ($urandom_range(0, 7) == 0) pf_k = !pf_k;
      en_k = ($urandom_range(0, 39) != 0);
      step();
    end
    hbs = 0;
    foreach (dut_log[j]) begin d = dut_log[j].data; if (d[255:240] == 16'hA5FF) hbs++; end
    checks++;
    if (hbs == 0) begin errors++; $display("FAIL rand_hb: actual 0 heartbeats required >0"); end
    check_logs("random");
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin gate[k] = 0; src_next[k] = 0; src_end[k] = 0; end
    en_k = 0; pf_k = 0;
    drive();
    @(negedge clk);
    test_reset();
    test_single_stream();
    test_all_four();
    test_backpressure();
    test_heartbeat();
    test_reset_mid_burst();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
